// File: rtl/alu_core.sv
// rtl/alu_core.sv - 32-bit registered integer ALU with C/S/O/Z flags (optional MUL via ALU_MUL_EN)

`define OP_NOP   5'd0
`define OP_ADD   5'd1
`define OP_SUB   5'd2
`define OP_AND   5'd3
`define OP_OR    5'd4
`define OP_XOR   5'd5
`define OP_NOT   5'd6
`define OP_SHL   5'd7
`define OP_SHR   5'd8
`define OP_SAR   5'd9
`define OP_INC   5'd10
`define OP_DEC   5'd11
`define OP_NEG   5'd12
`define OP_PASSA 5'd13
`define OP_PASSB 5'd14
`define OP_CMP   5'd15
`define OP_MUL   5'd16

module alu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] operando_a,
  input  logic [31:0] operando_b,
  input  logic [4:0]  opcode,
  output logic [31:0] resultado,
  output logic        C,
  output logic        S,
  output logic        O,
  output logic        Z
);

  // Shared adder: every arithmetic op is expressed as add_x + add_y + add_cin
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_cin;
  logic [32:0] sum;
  logic        add_ovf;

  // Shifts carry one extra bit so the last bit shifted out lands in a fixed place
  logic [4:0]  shamt;
  logic [32:0] shl_t;
  logic [32:0] shr_t;
  logic [32:0] sar_t;

`ifdef ALU_MUL_EN
  logic [63:0] product;
`endif

  logic [31:0] nxt_r;
  logic [31:0] flag_src;
  logic        nxt_c;
  logic        nxt_o;

  // Select adder operands; unary ops never route operando_b so X on it cannot leak
  always_comb begin
    add_x   = operando_a;
    add_y   = 32'd0;
    add_cin = 1'b0;
    case (opcode)
      `OP_ADD: add_y = operando_b;
      `OP_SUB, `OP_CMP: begin
        add_y   = ~operando_b;
        add_cin = 1'b1;
      end
      `OP_INC: add_cin = 1'b1;
      `OP_DEC: begin
        add_y   = 32'hFFFF_FFFE;
        add_cin = 1'b1;
      end
      `OP_NEG: begin
        add_x   = 32'd0;
        add_y   = ~operando_a;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum     = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
  assign add_ovf = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);

  assign shamt = operando_b[4:0];
  assign shl_t = {1'b0, operando_a} << shamt;
  assign shr_t = {operando_a, 1'b0} >> shamt;
  assign sar_t = $signed({operando_a, 1'b0}) >>> shamt;

`ifdef ALU_MUL_EN
  assign product = {32'd0, operando_a} * {32'd0, operando_b};
`endif

  // Next result and C/O per opcode; NOP and CMP keep the stored result
  always_comb begin
    nxt_r    = resultado;
    nxt_c    = C;
    nxt_o    = O;
    case (opcode)
      `OP_NOP: ;
      `OP_ADD, `OP_SUB, `OP_INC, `OP_DEC, `OP_NEG: begin
        nxt_r = sum[31:0];
        nxt_c = sum[32];
        nxt_o = add_ovf;
      end
      `OP_CMP: begin
        nxt_c = sum[32];
        nxt_o = add_ovf;
      end
      `OP_AND:   begin nxt_r = operando_a & operando_b; nxt_c = 1'b0; nxt_o = 1'b0; end
      `OP_OR:    begin nxt_r = operando_a | operando_b; nxt_c = 1'b0; nxt_o = 1'b0; end
      `OP_XOR:   begin nxt_r = operando_a ^ operando_b; nxt_c = 1'b0; nxt_o = 1'b0; end
      `OP_NOT:   begin nxt_r = ~operando_a;             nxt_c = 1'b0; nxt_o = 1'b0; end
      `OP_PASSA: begin nxt_r = operando_a;              nxt_c = 1'b0; nxt_o = 1'b0; end
      `OP_PASSB: begin nxt_r = operando_b;              nxt_c = 1'b0; nxt_o = 1'b0; end
      `OP_SHL:   begin nxt_r = shl_t[31:0]; nxt_c = shl_t[32]; nxt_o = 1'b0; end
      `OP_SHR:   begin nxt_r = shr_t[32:1]; nxt_c = shr_t[0];  nxt_o = 1'b0; end
      `OP_SAR:   begin nxt_r = sar_t[32:1]; nxt_c = sar_t[0];  nxt_o = 1'b0; end
`ifdef ALU_MUL_EN
      `OP_MUL: begin
        nxt_r = product[31:0];
        nxt_c = |product[63:32];
        nxt_o = |product[63:32];
      end
`endif
      default: begin
        nxt_r = 32'd0;
        nxt_c = 1'b0;
        nxt_o = 1'b0;
      end
    endcase
  end

  // S and Z follow the new result, except CMP which flags the discarded difference
  assign flag_src = (opcode == `OP_CMP) ? sum[31:0] : nxt_r;

  // Output register: async clear, NOP leaves everything untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultado <= 32'd0;
      C         <= 1'b0;
      S         <= 1'b0;
      O         <= 1'b0;
      Z         <= 1'b1;
    end else if (opcode != `OP_NOP) begin
      resultado <= nxt_r;
      C         <= nxt_c;
      O         <= nxt_o;
      S         <= flag_src[31];
      Z         <= (flag_src == 32'd0);
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - scoreboard bench for alu_core

module tb_alu_core;

  localparam logic [4:0] NOP = 5'd0,  ADD = 5'd1,  SUB = 5'd2,   AND_ = 5'd3,
                         OR_ = 5'd4,  XOR_ = 5'd5, NOT_ = 5'd6,  SHL = 5'd7,
                         SHR = 5'd8,  SAR = 5'd9,  INC = 5'd10,  DEC = 5'd11,
                         NEG = 5'd12, PASSA = 5'd13, PASSB = 5'd14, CMP = 5'd15,
                         MUL = 5'd16;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        s;
    logic        o;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] operando_a = 32'd0;
  logic [31:0] operando_b = 32'd0;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] resultado;
  logic        C, S, O, Z;

  int tests = 0;
  int fails = 0;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  prev;

  alu_core dut (
    .clk        (clk),
    .reset      (reset),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .opcode     (opcode),
    .resultado  (resultado),
    .C          (C),
    .S          (S),
    .O          (O),
    .Z          (Z)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_val();
    exp_t e;
    e.r = 32'd0; e.c = 1'b0; e.s = 1'b0; e.o = 1'b0; e.z = 1'b1;
    return e;
  endfunction

  // Reference model: 64-bit arithmetic and bit-by-bit shifting
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input exp_t p);
    exp_t e;
    logic [63:0] w;
    longint sa, sb, sd;
    logic [31:0] diff;
    logic [31:0] x, y;
    int n;
    bit sub;
    e = p;
    x = a; y = b; sub = 0;
    case (op)
      NOP: return p;
      INC: begin y = 32'd1; end
      DEC: begin y = 32'd1; sub = 1; end
      NEG: begin x = 32'd0; y = a; sub = 1; end
      SUB, CMP: sub = 1;
      default: ;
    endcase
    case (op)
      ADD, INC, SUB, CMP, DEC, NEG: begin
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        if (sub) begin
          w = {32'd0, x} - {32'd0, y};
          e.c = (x >= y);
          sd = sa - sb;
        end else begin
          w = {32'd0, x} + {32'd0, y};
          e.c = w[32];
          sd = sa + sb;
        end
        diff = w[31:0];
        e.o = (sd != longint'($signed(diff)));
        e.r = (op == CMP) ? p.r : diff;
        e.s = diff[31];
        e.z = (diff == 32'd0);
        return e;
      end
      AND_:  e.r = a & b;
      OR_:   e.r = a | b;
      XOR_:  e.r = a ^ b;
      NOT_:  e.r = ~a;
      PASSA: e.r = a;
      PASSB: e.r = b;
      SHL, SHR, SAR: begin
        n = int'(b[4:0]);
        e.r = a;
        e.c = 1'b0;
        for (int i = 0; i < n; i++) begin
          if (op == SHL) begin
            e.c = e.r[31];
            e.r = {e.r[30:0], 1'b0};
          end else begin
            e.c = e.r[0];
            e.r = {(op == SAR) ? e.r[31] : 1'b0, e.r[31:1]};
          end
        end
        e.o = 1'b0;
        e.s = e.r[31];
        e.z = (e.r == 32'd0);
        return e;
      end
`ifdef ALU_MUL_EN
      MUL: begin
        w = {32'd0, a} * {32'd0, b};
        e.r = w[31:0];
        e.c = (w[63:32] != 32'd0);
        e.o = e.c;
        e.s = e.r[31];
        e.z = (e.r == 32'd0);
        return e;
      end
`endif
      default: return reset_val();
    endcase
    e.c = 1'b0;
    e.o = 1'b0;
    e.s = e.r[31];
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk(tag, "R", resultado, e.r);
    chk(tag, "C", {31'd0, C}, {31'd0, e.c});
    chk(tag, "S", {31'd0, S}, {31'd0, e.s});
    chk(tag, "O", {31'd0, O}, {31'd0, e.o});
    chk(tag, "Z", {31'd0, Z}, {31'd0, e.z});
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode     = op;
    operando_a = a;
    operando_b = b;
  endtask

  task automatic collect();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk_all(t, e);
    end
  endtask

  task automatic op_model(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    drive(op, a, b);
    e = model(op, a, b, prev);
    prev = e;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    collect();
  endtask

  task automatic op_exp(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic c, input logic s,
                        input logic o, input logic z);
    exp_t e;
    drive(op, a, b);
    e.r = r; e.c = c; e.s = s; e.o = o; e.z = z;
    prev = e;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    collect();
  endtask

  initial begin
    logic [31:0] ra, rb;
    prev = reset_val();
    #1 reset = 1'b1;
    #2;
    chk_all("reset_async", reset_val());
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", reset_val());
    @(negedge clk);
    reset = 1'b0;

    op_exp("nop_after_reset", NOP, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1);
    op_exp("add_min_min", ADD, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 0, 1, 1);
    op_exp("add_neg_neg", ADD, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFE_FFFF, 1, 1, 0, 0);
    op_exp("add_neg_pos", ADD, 32'hFFFF_0000, 32'h0FFF_1111, 32'h0FFE_1111, 1, 0, 0, 0);
    op_exp("add_pos_ovf1", ADD, 32'h7FFF_0000, 32'h7FFF_1111, 32'hFFFE_1111, 0, 1, 1, 0);
    op_exp("add_pos_ovf2", ADD, 32'h7FFF_0000, 32'h0FFF_1111, 32'h8FFE_1111, 0, 1, 1, 0);
    op_exp("nop_hold", NOP, 32'h1234_5678, 32'h9ABC_DEF0, 32'h8FFE_1111, 0, 1, 1, 0);
    op_exp("not_bx", NOT_, 32'hACED_CAFE, 32'hxxxx_xxxx, 32'h5312_3501, 0, 0, 0, 0);
    op_exp("not_back", NOT_, 32'h5312_3501, 32'hxxxx_xxxx, 32'hACED_CAFE, 0, 1, 0, 0);
    op_exp("sub_5_7", SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1, 0, 0);
    op_exp("cmp_eq", CMP, 32'd7, 32'd7, 32'hFFFF_FFFE, 1, 0, 0, 1);
    op_exp("inc_wrap", INC, 32'hFFFF_FFFF, 32'hxxxx_xxxx, 32'h0, 1, 0, 0, 1);
    op_exp("dec_min", DEC, 32'h8000_0000, 32'hxxxx_xxxx, 32'h7FFF_FFFF, 1, 0, 1, 0);
    op_exp("neg_min", NEG, 32'h8000_0000, 32'hxxxx_xxxx, 32'h8000_0000, 0, 1, 1, 0);
    op_exp("neg_zero", NEG, 32'h0, 32'hxxxx_xxxx, 32'h0, 1, 0, 0, 1);
    op_exp("shl_1", SHL, 32'h8000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 1, 0, 0, 0);
    op_exp("shr_1", SHR, 32'h0000_0001, 32'd1, 32'h0, 1, 0, 0, 1);
    op_exp("sar_31", SAR, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, 1, 0, 0);
    op_exp("shl_0", SHL, 32'hF000_000F, 32'h0000_0020, 32'hF000_000F, 0, 1, 0, 0);
    op_exp("undef_20", 5'd20, 32'hDEAD_BEEF, 32'h1, 32'h0, 0, 0, 0, 1);

    for (int i = 0; i < 17; i++) begin
      ra = $urandom;
      rb = $urandom;
      op_model($sformatf("rand_op%0d", i), 5'(i), ra, rb);
    end
    op_model("op16_big", MUL, 32'h0001_0000, 32'h0001_0003);
    op_model("op16_small", MUL, 32'd1234, 32'd5678);
    op_model("sar_pos", SAR, 32'h4000_0003, 32'd2);
    op_model("undef_31", 5'd31, 32'h1, 32'h2);

    // Reset mid-stream: pending ADD capture must be discarded
    drive(ADD, 32'h1234_0000, 32'h0000_5678);
    #2 reset = 1'b1;
    #1;
    chk_all("reset_mid_async", reset_val());
    @(posedge clk);
    #1;
    chk_all("reset_mid_edge", reset_val());
    @(negedge clk);
    reset = 1'b0;
    prev = reset_val();
    op_exp("first_after_reset", ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
